// File: rtl/mmc1_serial_writer.sv
// Emulated 6502 bus master that loads one MMC1 register through its 5-bit
// serial port, optionally preceded by a shift-register reset write.
module mmc1_serial_writer #(
  parameter int CYC_LEN   = 12,
  parameter int RST_FIRST = 1
) (
  input  logic        clk,
  input  logic        map_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_reg,
  input  logic [4:0]  cmd_dat,
  input  logic        cmd_rst,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_dat,
  output logic        cpu_rw,
  output logic        cpu_ce,
  output logic        m2,
  output logic        busy,
  output logic        done
);

  localparam int PW = (CYC_LEN > 2) ? $clog2(CYC_LEN) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CYC_LEN - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(CYC_LEN / 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RSTW = 3'd1,
    S_RGAP = 3'd2,
    S_BITW = 3'd3,
    S_BGAP = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [2:0]     idx_q, idx_d;
  logic [1:0]     reg_q, reg_d;
  logic [4:0]     dat_q, dat_d;
  logic           rst_q, rst_d;

  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           m2_q, m2_d;
  logic           ce_q, ce_d;
  logic           rw_q, rw_d;
  logic [14:0]    addr_q, addr_d;
  logic [7:0]     bus_q, bus_d;

  logic           last_s;
  logic           cyc_s;

  assign last_s = (phase_q == PH_LAST);
  assign cyc_s  = (state_q == S_RSTW) || (state_q == S_RGAP) ||
                  (state_q == S_BITW) || (state_q == S_BGAP);

  // Next-state, command latch and next registered bus outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    reg_d   = reg_q;
    dat_d   = dat_q;
    rst_d   = rst_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          reg_d   = cmd_reg;
          dat_d   = cmd_dat;
          rst_d   = cmd_rst;
          idx_d   = 3'd0;
          state_d = ((RST_FIRST != 0) || cmd_rst) ? S_RSTW : S_BITW;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RSTW: begin
        if (last_s) begin
          state_d = S_RGAP;
        end else begin
          state_d = S_RSTW;
        end
      end
      S_RGAP: begin
        if (last_s) begin
          if (rst_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BITW;
            idx_d   = 3'd0;
          end
        end else begin
          state_d = S_RGAP;
        end
      end
      S_BITW: begin
        if (last_s) begin
          state_d = S_BGAP;
        end else begin
          state_d = S_BITW;
        end
      end
      S_BGAP: begin
        if (last_s) begin
          if (idx_q < 3'd4) begin
            state_d = S_BITW;
            idx_d   = idx_q + 3'd1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_BGAP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Phase restarts on every bus-cycle boundary, so outputs only move at phase 0.
    phase_d = (cyc_s && !last_s) ? (phase_q + PW'(1)) : {PW{1'b0}};

    ce_d   = 1'b1;
    rw_d   = 1'b1;
    addr_d = 15'h0000;
    bus_d  = 8'h00;
    case (state_d)
      S_RSTW: begin
        ce_d  = 1'b0;
        rw_d  = 1'b0;
        bus_d = 8'h80;
      end
      S_BITW: begin
        ce_d   = 1'b0;
        rw_d   = 1'b0;
        addr_d = {reg_d, 13'h0000};
        bus_d  = {7'b0000000, dat_d[idx_d]};
      end
      default: begin
        ce_d   = 1'b1;
        rw_d   = 1'b1;
        addr_d = 15'h0000;
        bus_d  = 8'h00;
      end
    endcase

    m2_d    = (phase_d >= PH_HALF);
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, command and output registers; reset forces the idle bus at once.
  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      state_q <= S_IDLE;
      phase_q <= {PW{1'b0}};
      idx_q   <= 3'd0;
      reg_q   <= 2'd0;
      dat_q   <= 5'd0;
      rst_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      m2_q    <= 1'b0;
      ce_q    <= 1'b1;
      rw_q    <= 1'b1;
      addr_q  <= 15'h0000;
      bus_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      reg_q   <= reg_d;
      dat_q   <= dat_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      m2_q    <= m2_d;
      ce_q    <= ce_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      bus_q   <= bus_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign m2        = m2_q;
  assign cpu_ce    = ce_q;
  assign cpu_rw    = rw_q;
  assign cpu_addr  = addr_q;
  assign cpu_dat   = bus_q;

endmodule

// File: tb/tb_mmc1_serial_writer.sv
// Bench for mmc1_serial_writer: two instances (RST_FIRST=0 and 1, CYC_LEN=4)
// checked against an MMC1 serial receiver model and a write-list reference.
module tb_mmc1_serial_writer;

  logic              clk = 1'b0;
  logic              map_rst_n;
  logic [1:0]        valid, rdy, crst, rw, ce, m2, busy, done;
  logic [1:0][1:0]   creg;
  logic [1:0][4:0]   cdat;
  logic [1:0][14:0]  addr;
  logic [1:0][7:0]   odat;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mmc1_serial_writer #(.CYC_LEN(4), .RST_FIRST(g)) u_dut (
      .clk(clk), .map_rst_n(map_rst_n),
      .cmd_valid(valid[g]), .cmd_ready(rdy[g]),
      .cmd_reg(creg[g]), .cmd_dat(cdat[g]), .cmd_rst(crst[g]),
      .cpu_addr(addr[g]), .cpu_dat(odat[g]), .cpu_rw(rw[g]), .cpu_ce(ce[g]),
      .m2(m2[g]), .busy(busy[g]), .done(done[g])
    );
  end

  // Bus monitor and MMC1 receiver model: a write is taken on the m2 falling edge.
  logic        pm2 [2] = '{1'b0, 1'b0};
  logic        pwr [2] = '{1'b0, 1'b0};
  logic [14:0] paddr [2];
  logic [7:0]  pdat [2];
  int          runlen [2] = '{0, 0};
  int          wtot [2] = '{0, 0};
  logic [22:0] wlog [2][64];
  logic [4:0]  rx_sr [2] = '{5'd0, 5'd0};
  int          rx_n [2] = '{0, 0};
  logic [4:0]  rx_reg [2][4];
  int          mon_bad = 0;

  function automatic logic [4:0] shift_in(logic [4:0] sr, logic b);
    return {b, sr[4:1]};
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!map_rst_n) begin
        pm2[k]    <= 1'b0;
        pwr[k]    <= 1'b0;
        runlen[k] <= 0;
      end else begin
        if (pm2[k] && m2[k] && ((addr[k] != paddr[k]) || (odat[k] != pdat[k]) ||
                                ((!ce[k] && !rw[k]) != pwr[k])))
          mon_bad <= mon_bad + 1;
        if (pm2[k] && !m2[k] && pwr[k]) begin
          wlog[k][wtot[k] % 64] <= {paddr[k], pdat[k]};
          wtot[k] <= wtot[k] + 1;
          if (pdat[k][7]) begin
            rx_sr[k] <= 5'd0;
            rx_n[k]  <= 0;
          end else if (rx_n[k] == 4) begin
            rx_reg[k][paddr[k][14:13]] <= shift_in(rx_sr[k], pdat[k][0]);
            rx_sr[k] <= 5'd0;
            rx_n[k]  <= 0;
          end else begin
            rx_sr[k] <= shift_in(rx_sr[k], pdat[k][0]);
            rx_n[k]  <= rx_n[k] + 1;
          end
        end
        if (!ce[k] && !rw[k]) begin
          runlen[k] <= runlen[k] + 1;
        end else begin
          if (pwr[k] && (runlen[k] != 4)) mon_bad <= mon_bad + 1;
          runlen[k] <= 0;
        end
        pm2[k]   <= m2[k];
        pwr[k]   <= !ce[k] && !rw[k];
        paddr[k] <= addr[k];
        pdat[k]  <= odat[k];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs(int k);
    return {3'b000, rdy[k], busy[k], done[k], m2[k], ce[k], rw[k], addr[k], odat[k]};
  endfunction

  function automatic logic [31:0] idle_exp(logic r);
    return {3'b000, r, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 15'h0000, 8'h00};
  endfunction

  // Reference write list of a command, written straight from the protocol.
  function automatic int exp_count(int k, logic rs);
    if (rs) return 1;
    return (k == 1) ? 6 : 5;
  endfunction

  function automatic logic [22:0] exp_write(int k, logic [1:0] r, logic [4:0] d, logic rs, int i);
    int j;
    if ((rs || k == 1) && i == 0) return {15'h0000, 8'h80};
    j = (k == 1) ? i - 1 : i;
    return {r, 13'h0000, 7'b0000000, d[j]};
  endfunction

  task automatic wait_done(input int k, output int n);
    n = 0;
    while (!done[k] && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic chk_writes(input int k, input int base, input logic [1:0] r,
                            input logic [4:0] d, input logic rs);
    int cnt, ne;
    cnt = wtot[k] - base;
    ne  = exp_count(k, rs);
    chk("write_count", cnt, ne);
    for (int i = 0; i < ne && i < cnt; i++)
      chk("write_data", wlog[k][(base + i) % 64], exp_write(k, r, d, rs, i));
  endtask

  task automatic run_cmd(input int k, input logic [1:0] r, input logic [4:0] d,
                         input logic rs, input int exp_len);
    int w, n, base;
    w = 0;
    while (!rdy[k] && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("accept_wait", rdy[k], 1);
    creg[k] = r; cdat[k] = d; crst[k] = rs; valid[k] = 1'b1;
    @(posedge clk); #1;
    base = wtot[k];
    valid[k] = 1'b0;
    creg[k] = 2'($urandom); cdat[k] = 5'($urandom); crst[k] = 1'($urandom);
    chk("accepted", {busy[k], rdy[k]}, 2'b10);
    wait_done(k, n);
    chk("latency", n, exp_len);
    chk("ready_in_done", rdy[k], 0);
    @(posedge clk); #1;
    chk("post_done", {done[k], busy[k], rdy[k]}, 3'b001);
    chk_writes(k, base, r, d, rs);
    if (!rs) chk("rx_reg", rx_reg[k][r], d);
  endtask

  typedef struct {
    int         k;
    logic [1:0] r;
    logic [4:0] d;
    logic       rs;
    int         len;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   n, bad, base1, base2;
    vecs[0] = '{1, 2'd3, 5'h15, 1'b0, 48};
    vecs[1] = '{0, 2'd1, 5'h1F, 1'b0, 40};
    vecs[2] = '{1, 2'd0, 5'h0A, 1'b1, 8};
    vecs[3] = '{0, 2'd2, 5'h0A, 1'b1, 8};
    vecs[4] = '{1, 2'd0, 5'h00, 1'b0, 48};
    vecs[5] = '{0, 2'd3, 5'h10, 1'b0, 40};

    valid = 2'b00; creg = '0; cdat = '0; crst = 2'b00;
    map_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_idle0", outs(0), idle_exp(1'b0));
    chk("reset_idle1", outs(1), idle_exp(1'b0));
    map_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", rdy, 2'b11);

    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) if (outs(k) !== idle_exp(1'b1)) bad++;
    end
    chk("idle_hold", bad, 0);

    for (int i = 0; i < 6; i++)
      run_cmd(vecs[i].k, vecs[i].r, vecs[i].d, vecs[i].rs, vecs[i].len);

    // Back-to-back with cmd_valid held and inputs changed while busy.
    creg[1] = 2'd2; cdat[1] = 5'h0C; crst[1] = 1'b0; valid[1] = 1'b1;
    @(posedge clk); #1;
    base1 = wtot[1];
    chk("b2b_accept1", {busy[1], rdy[1]}, 2'b10);
    creg[1] = 2'd1; cdat[1] = 5'h13;
    wait_done(1, n);
    chk("b2b_latency1", n, 48);
    @(posedge clk); #1;
    chk("b2b_idle_clk", {busy[1], rdy[1]}, 2'b01);
    @(posedge clk); #1;
    base2 = wtot[1];
    chk("b2b_accept2", {busy[1], rdy[1]}, 2'b10);
    valid[1] = 1'b0;
    chk_writes(1, base1, 2'd2, 5'h0C, 1'b0);
    chk("b2b_rx1", rx_reg[1][2], 5'h0C);
    wait_done(1, n);
    chk("b2b_latency2", n, 48);
    @(posedge clk); #1;
    chk_writes(1, base2, 2'd1, 5'h13, 1'b0);
    chk("b2b_rx2", rx_reg[1][1], 5'h13);

    // Reset during the third data write while m2 is high.
    creg[1] = 2'd2; cdat[1] = 5'h0B; crst[1] = 1'b0; valid[1] = 1'b1;
    @(posedge clk); #1;
    valid[1] = 1'b0;
    repeat (26) @(posedge clk);
    #1;
    chk("mid_write", {m2[1], ce[1], rw[1], addr[1], odat[1]}, {3'b100, 15'h4000, 8'h00});
    #2 map_rst_n = 1'b0;
    #1;
    chk("rst_immediate1", outs(1), idle_exp(1'b0));
    chk("rst_immediate0", outs(0), idle_exp(1'b0));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_held", outs(1), idle_exp(1'b0));
    map_rst_n = 1'b1;
    #1;
    chk("ready_before_edge", rdy[1], 0);
    @(posedge clk); #1;
    chk("ready_after_release", rdy, 2'b11);
    run_cmd(1, 2'd1, 5'h13, 1'b0, 48);

    for (int i = 0; i < 1000; i++) begin
      int         k;
      logic       rs;
      logic [1:0] r;
      logic [4:0] d;
      k  = (i < 600) ? 1 : 0;
      r  = 2'($urandom);
      d  = 5'($urandom);
      rs = ($urandom_range(0, 7) == 0);
      run_cmd(k, r, d, rs, rs ? 8 : ((k == 1) ? 48 : 40));
    end

    chk("bus_monitor", mon_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmc1_serial_writer.md
MMC1_SERIAL_WRITER -- requirements
Module: mmc1_serial_writer

Interface
REQ-001 The module SHALL have parameter CYC_LEN, default 12, giving clk cycles per emulated CPU bus cycle; it SHALL be even and at least 4.
REQ-002 The module SHALL have parameter RST_FIRST, default 1; when 1, every command is preceded by a shift-register reset write.
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-004 The module SHALL have port map_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port cmd_valid, input, 1 bit: a command is presented.
REQ-006 The module SHALL have port cmd_ready, output, 1 bit: the block can accept a command; high only in IDLE.
REQ-007 The module SHALL have port cmd_reg, input, 2 bits: the target register, which drives cpu_addr[14:13].
REQ-008 The module SHALL have port cmd_dat, input, 5 bits: the register value, sent LSB first.
REQ-009 The module SHALL have port cmd_rst, input, 1 bit: when 1, the command is a reset write only, with no data bits.
REQ-010 The module SHALL have port cpu_addr, output, 15 bits: the emulated CPU address.
REQ-011 The module SHALL have port cpu_dat, output, 8 bits: the emulated CPU write data.
REQ-012 The module SHALL have port cpu_rw, output, 1 bit: 0 means write.
REQ-013 The module SHALL have port cpu_ce, output, 1 bit: ROM-area select, active-low; 0 means an access in $8000-$FFFF.
REQ-014 The module SHALL have port m2, output, 1 bit: the emulated CPU phase-2 clock.
REQ-015 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 The module SHALL have port done, output, 1 bit: a one-clk pulse at the end of each command.

Function
REQ-017 A command SHALL be accepted on the clk edge where cmd_valid && cmd_ready; cmd_reg, cmd_dat and cmd_rst are latched on that edge, and later changes to the inputs SHALL be ignored until IDLE is re-entered.
REQ-018 The FSM SHALL have states IDLE, RSTW, RGAP, BITW, BGAP and DONE; each state except IDLE and DONE lasts exactly one bus cycle of CYC_LEN clks.
REQ-019 On acceptance, the FSM SHALL go to RSTW if RST_FIRST || cmd_rst, otherwise to BITW with bit index 0.
REQ-020 A phase counter SHALL run 0..CYC_LEN-1 and wrap to 0 while busy; it SHALL be held at 0 in IDLE and DONE.
REQ-021 m2 SHALL be high for phases CYC_LEN/2..CYC_LEN-1 and low otherwise; m2 SHALL be 0 in IDLE and DONE.
REQ-022 In RSTW, outputs SHALL be cpu_ce=0, cpu_rw=0, cpu_addr=15'h0000, cpu_dat=8'h80 for the whole bus cycle.
REQ-023 At the end of RSTW, the FSM SHALL go to RGAP.
REQ-024 At the end of RGAP, the FSM SHALL go to DONE if the latched cmd_rst is 1, otherwise to BITW with index 0.
REQ-025 In BITW, outputs SHALL be cpu_ce=0, cpu_rw=0, cpu_addr={cmd_reg,13'h0000}, cpu_dat={7'b0, cmd_dat[index]}.
REQ-026 The bit index SHALL count 0..4 (3 bits); it SHALL increment at the end of each BGAP and SHALL never exceed 4.
REQ-027 At the end of BGAP, the FSM SHALL go to BITW if index<4, otherwise to DONE.
REQ-028 In RGAP, BGAP, IDLE and DONE, outputs SHALL be cpu_ce=1, cpu_rw=1, cpu_addr=0, cpu_dat=0; every write is therefore followed by at least one full non-write bus cycle, so the receiver's write-edge detection re-arms.
REQ-029 Write outputs SHALL change only on the clk edge that starts phase 0, so they are stable across the whole m2-high window, including its falling edge.
REQ-030 DONE SHALL last one clk, with done=1; the FSM SHALL then go to IDLE, and cmd_ready=1 on the following clk.
REQ-031 The data-command length SHALL be 2*(5+RST_FIRST)*CYC_LEN clks from acceptance to DONE; the cmd_rst length SHALL be 2*CYC_LEN.
REQ-032 cmd_valid held high continuously SHALL produce back-to-back commands separated by exactly the one IDLE clk.
REQ-033 cmd_valid low in IDLE SHALL keep all outputs at their idle values indefinitely.

Reset
REQ-034 While map_rst_n=0, and immediately on its assertion (including mid-write), outputs SHALL be: cmd_ready=0, busy=0, done=0, m2=0, cpu_ce=1, cpu_rw=1, cpu_addr=0, cpu_dat=0.
REQ-035 During reset, the FSM SHALL be in IDLE and the phase counter, bit index and latched command SHALL be cleared.
REQ-036 An interrupted command SHALL be discarded and never resumed.
REQ-037 cmd_ready SHALL rise on the first clk edge after map_rst_n deasserts.

Verification
REQ-038 Basic data command: CYC_LEN=4, RST_FIRST=1, cmd_reg=3, cmd_dat=5'h15 -> cpu_dat sequence 80,01,00,01,00,01; addresses 0000 then 6000 five times; each write 4 clks with a 4-clk gap; done 48 clks after acceptance.
REQ-039 No reset write: RST_FIRST=0, cmd_reg=1, cmd_dat=5'h1F -> five writes of 01 at 2000; done 40 clks after acceptance (CYC_LEN=4).
REQ-040 Reset-only command: cmd_rst=1, cmd_dat=5'h0A -> a single 80 write at 0000; no data writes; done 8 clks after acceptance (CYC_LEN=4).
REQ-041 Back-to-back: cmd_valid held high with two commands -> second accepted exactly 1 clk after the first done; cmd_valid and cmd_dat changed during busy -> no effect on the first command.
REQ-042 Reset during the third BITW while m2=1 -> outputs reach idle values immediately without a clk edge; cmd_ready=1 one clk after release; the next command starts from its first write.
REQ-043 Scoreboard: pair the writer with the MMC1-style serial receiver model and 1000 random cmd_reg and cmd_dat values -> the receiver register equals cmd_dat after every done.
